// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: FSM state encoding, grant record,
// and the opcode classes understood by alu_component.
// Optional feature macro: ALU_ARB_OPCHECK_EN (uses is_legal_op below).
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    // Result of one arbitration decision.
    typedef struct packed {
        logic valid;
        logic win;
    } grant_t;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;

    function automatic logic is_add_op(input logic [3:0] op);
        case (op)
            4'b0000, 4'b0100, 4'b0110, 4'b1000,
            4'b1001, 4'b1010, 4'b1011: is_add_op = 1'b1;
            default:                   is_add_op = 1'b0;
        endcase
    endfunction

    function automatic logic is_sub_op(input logic [3:0] op);
        case (op)
            4'b0001, 4'b0010, 4'b0011,
            4'b0101, 4'b1100:          is_sub_op = 1'b1;
            default:                   is_sub_op = 1'b0;
        endcase
    endfunction

    function automatic logic is_legal_op(input logic [3:0] op);
        is_legal_op = is_add_op(op) | is_sub_op(op);
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Bus between the two ALU requesters and the arbiter.
// Handshake: a requester raises reqN with opN/aN/bN stable and holds them
// until it sees the one-cycle ackN pulse (operands latched); it must drop reqN
// by the edge ending that ack cycle. One cycle after ackN, doneN pulses for one
// cycle and result/zero/pos (and illegal_op when ALU_ARB_OPCHECK_EN is defined)
// are valid only in that cycle. state is the arbiter FSM state for observation.
interface alu_arbiter_if
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int OP_W  = 4
);
    logic             req0;
    logic [OP_W-1:0]  op0;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic             req1;
    logic [OP_W-1:0]  op1;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             ack0;
    logic             ack1;
    logic             done0;
    logic             done1;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             pos;
    logic             busy;
    arb_state_t       state;
`ifdef ALU_ARB_OPCHECK_EN
    logic             illegal_op;
`endif

    modport master (
        output req0, op0, a0, b0, req1, op1, a1, b1,
`ifdef ALU_ARB_OPCHECK_EN
        input  illegal_op,
`endif
        input  ack0, ack1, done0, done1, result, zero, pos, busy, state
    );

    modport slave (
        input  req0, op0, a0, b0, req1, op1, a1, b1,
`ifdef ALU_ARB_OPCHECK_EN
        output illegal_op,
`endif
        output ack0, ack1, done0, done1, result, zero, pos, busy, state
    );

endinterface

// File: rtl/alu_component.sv
// The datapath ALU: combinational add/sub selected by opcode class, with
// zero and signed-positive flags. Unknown opcodes produce 0. Its reset is
// active-high and forces the output to 0.
module alu_component
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int OP_W  = 4
) (
    input  logic             reset,
    input  logic [OP_W-1:0]  inst_id,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             pos
);

    // Opcode decode and arithmetic.
    always_comb begin
        out = '0;
        if (reset) begin
            out = '0;
        end else if (is_add_op(inst_id)) begin
            out = in0 + in1;
        end else if (is_sub_op(inst_id)) begin
            out = in0 - in1;
        end
    end

    assign zero = (out == '0);
    assign pos  = ~out[WIDTH-1] & (out != '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one alu_component between the execute stage
// (requester 0) and the address/PC-increment unit (requester 1).
// Operands are latched on grant, the ALU runs from registers, and the
// result/flags are registered for the winner.
// Optional feature macro: ALU_ARB_OPCHECK_EN -- illegal opcodes bypass the
// ALU (result/flags 0) and raise illegal_op with done.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int OP_W  = 4
) (
    input logic        clk,
    input logic        reset,
    alu_arbiter_if.slave bus
);

    arb_state_t       state;
    logic [OP_W-1:0]  op_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             win_r;
    logic             last_grant;
    logic             ack0_r;
    logic             ack1_r;
    logic             done0_r;
    logic             done1_r;
    logic [WIDTH-1:0] result_r;
    logic             zero_r;
    logic             pos_r;
    logic             busy_r;
    grant_t           grant;

    logic [WIDTH-1:0] alu_out;
    logic             alu_zero;
    logic             alu_pos;

    // Single request wins outright; on a tie the side not served last wins.
    function automatic grant_t pick_winner(input logic r0, input logic r1,
                                           input logic last);
        grant_t g;
        g.valid = r0 | r1;
        if (r0 && r1) begin
            g.win = ~last;
        end else begin
            g.win = r1 & ~r0;
        end
        return g;
    endfunction

    // Arbitration decision for the current cycle.
    always_comb begin
        grant = pick_winner(bus.req0, bus.req1, last_grant);
    end

    alu_component #(
        .WIDTH (WIDTH),
        .OP_W  (OP_W)
    ) u_alu (
        .reset   (1'b0),
        .inst_id (op_r),
        .in0     (a_r),
        .in1     (b_r),
        .out     (alu_out),
        .zero    (alu_zero),
        .pos     (alu_pos)
    );

`ifdef ALU_ARB_OPCHECK_EN
    logic illegal_r;
`endif

    // Control FSM: IDLE/RESP arbitrate and latch, EXEC captures the ALU output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            op_r       <= '0;
            a_r        <= '0;
            b_r        <= '0;
            win_r      <= 1'b0;
            last_grant <= 1'b1;
            ack0_r     <= 1'b0;
            ack1_r     <= 1'b0;
            done0_r    <= 1'b0;
            done1_r    <= 1'b0;
            result_r   <= '0;
            zero_r     <= 1'b0;
            pos_r      <= 1'b0;
            busy_r     <= 1'b0;
`ifdef ALU_ARB_OPCHECK_EN
            illegal_r  <= 1'b0;
`endif
        end else begin
            // Handshake pulses last exactly one cycle.
            ack0_r  <= 1'b0;
            ack1_r  <= 1'b0;
            done0_r <= 1'b0;
            done1_r <= 1'b0;
`ifdef ALU_ARB_OPCHECK_EN
            illegal_r <= 1'b0;
`endif
            case (state)
                IDLE, RESP: begin
                    if (grant.valid) begin
                        state      <= EXEC;
                        busy_r     <= 1'b1;
                        win_r      <= grant.win;
                        last_grant <= grant.win;
                        if (grant.win) begin
                            op_r   <= bus.op1;
                            a_r    <= bus.a1;
                            b_r    <= bus.b1;
                            ack1_r <= 1'b1;
                        end else begin
                            op_r   <= bus.op0;
                            a_r    <= bus.a0;
                            b_r    <= bus.b0;
                            ack0_r <= 1'b1;
                        end
                    end else begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                    end
                end
                EXEC: begin
                    state   <= RESP;
                    busy_r  <= 1'b1;
                    done0_r <= ~win_r;
                    done1_r <= win_r;
`ifdef ALU_ARB_OPCHECK_EN
                    if (is_legal_op(op_r)) begin
                        result_r <= alu_out;
                        zero_r   <= alu_zero;
                        pos_r    <= alu_pos;
                    end else begin
                        result_r  <= '0;
                        zero_r    <= 1'b0;
                        pos_r     <= 1'b0;
                        illegal_r <= 1'b1;
                    end
`else
                    result_r <= alu_out;
                    zero_r   <= alu_zero;
                    pos_r    <= alu_pos;
`endif
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ack0   = ack0_r;
    assign bus.ack1   = ack1_r;
    assign bus.done0  = done0_r;
    assign bus.done1  = done1_r;
    assign bus.result = result_r;
    assign bus.zero   = zero_r;
    assign bus.pos    = pos_r;
    assign bus.busy   = busy_r;
    assign bus.state  = state;
`ifdef ALU_ARB_OPCHECK_EN
    assign bus.illegal_op = illegal_r;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: scoreboard of expected responses pushed at
// request time and popped on done. Define ALU_ARB_OPCHECK_EN to also cover
// the illegal-opcode path.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int W  = 16;
    localparam int EW = W + 4;   // {ch, illegal, result, zero, pos}

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   ack_cyc [2];
    int   done_cyc[2];
    logic [EW-1:0] exp_q[$];
    logic [3:0] legal_ops [12] = '{4'b0000, 4'b0100, 4'b0110, 4'b1000,
                                  4'b1001, 4'b1010, 4'b1011, 4'b0001,
                                  4'b0010, 4'b0011, 4'b0101, 4'b1100};

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_arbiter_if #(.WIDTH(W), .OP_W(4)) bif ();

    alu_arbiter #(.WIDTH(W), .OP_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Reference behaviour of one operation, packed as a scoreboard entry.
    function automatic logic [EW-1:0] model(input logic ch, input logic [3:0] op,
                                            input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        logic         ill;
        r   = '0;
        ill = 1'b0;
        case (op)
            4'b0000, 4'b0100, 4'b0110, 4'b1000, 4'b1001, 4'b1010, 4'b1011: r = a + b;
            4'b0001, 4'b0010, 4'b0011, 4'b0101, 4'b1100:                   r = a - b;
            default: ill = 1'b1;
        endcase
        if (ill) return {ch, 1'b1, {W{1'b0}}, 1'b0, 1'b0};
        return {ch, 1'b0, r, (r == '0), (!r[W-1] && r != '0)};
    endfunction

    task automatic drive(input int ch, input logic r, input logic [3:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        if (ch == 0) begin
            bif.req0 = r; bif.op0 = op; bif.a0 = a; bif.b0 = b;
        end else begin
            bif.req1 = r; bif.op1 = op; bif.a1 = a; bif.b1 = b;
        end
    endtask

    // Raise a request, wait (bounded) for ack, then drop req and scramble operands.
    task automatic req_op(input int ch, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, output int wait_cyc);
        @(negedge clk);
        drive(ch, 1'b1, op, a, b);
        wait_cyc = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if ((ch == 0 && bif.ack0) || (ch == 1 && bif.ack1)) begin
                wait_cyc = i;
                break;
            end
        end
        check("ack_timeout", (wait_cyc != 0), 1);
        drive(ch, 1'b0, $urandom_range(0, 15), 16'hFFFF, W'($urandom_range(0, 65535)));
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // Response monitor: one-hot handshakes, done-after-ack timing, scoreboard.
    always @(negedge clk) begin : monitor
        logic [EW-1:0] got;
        logic [EW-1:0] expv;
        logic          ch;
        logic          ill;
        if (bif.ack0) ack_cyc[0] = cyc;
        if (bif.ack1) ack_cyc[1] = cyc;
        if (bif.ack0 | bif.ack1) check("ack_one_hot", bif.ack0 & bif.ack1, 0);
        if (bif.done0 | bif.done1) begin
            check("done_one_hot", bif.done0 & bif.done1, 0);
            ch = bif.done1;
            check("done_after_ack", cyc, ack_cyc[ch] + 1);
            check("busy_in_resp", bif.busy, 1);
            done_cyc[ch] = cyc;
`ifdef ALU_ARB_OPCHECK_EN
            ill = bif.illegal_op;
`else
            ill = 1'b0;
`endif
            got = {ch, ill, bif.result, bif.zero, bif.pos};
            if (exp_q.size() == 0) begin
                check("unexpected_done", exp_q.size(), 1);
            end else begin
                expv = exp_q.pop_front();
                check("response", got, expv);
            end
        end
    end

    // Watchdog.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Directed stimulus.
    initial begin
        int w0, w1;
        logic [3:0]   op_x, op_y;
        logic [W-1:0] ax, bx, ay, by;
        ack_cyc  = '{-10, -10};
        done_cyc = '{0, 0};
        reset = 1'b0;
        drive(0, 1'b0, 4'h0, '0, '0);
        drive(1, 1'b0, 4'h0, '0, '0);
        repeat (3) @(negedge clk);

        // Reset state.
        check("rst_state",  bif.state, IDLE);
        check("rst_ack0",   bif.ack0, 0);
        check("rst_ack1",   bif.ack1, 0);
        check("rst_done0",  bif.done0, 0);
        check("rst_done1",  bif.done1, 0);
        check("rst_busy",   bif.busy, 0);
        check("rst_result", bif.result, 0);
        check("rst_zero",   bif.zero, 0);
        check("rst_pos",    bif.pos, 0);
        @(negedge clk);
        reset = 1'b1;

        // Single add on requester 0: 1+1 = 2.
        exp_q.push_back(model(0, 4'b0000, 16'd1, 16'd1));
        req_op(0, 4'b0000, 16'd1, 16'd1, w0);
        check("add_ack_latency", w0, 1);
        check("add_ack1_quiet", bif.ack1, 0);
        check("add_busy_exec", bif.busy, 1);
        repeat (2) @(negedge clk);
        check("add_drained", exp_q.size(), 0);
        check("add_idle_busy", bif.busy, 0);
        check("add_idle_state", bif.state, IDLE);

        // Single sub on requester 1: 1-1 = 0, zero set.
        exp_q.push_back(model(1, 4'b0001, 16'd1, 16'd1));
        req_op(1, 4'b0001, 16'd1, 16'd1, w1);
        check("sub_ack_latency", w1, 1);
        repeat (2) @(negedge clk);
        check("sub_drained", exp_q.size(), 0);

        // Wrap-around boundaries.
        exp_q.push_back(model(0, 4'b0000, 16'hFFFF, 16'h0001));
        req_op(0, 4'b0000, 16'hFFFF, 16'h0001, w0);
        exp_q.push_back(model(1, 4'b0001, 16'h0000, 16'h0001));
        req_op(1, 4'b0001, 16'h0000, 16'h0001, w1);
        exp_q.push_back(model(0, 4'b1100, 16'h8000, 16'h0001));
        req_op(0, 4'b1100, 16'h8000, 16'h0001, w0);
        repeat (2) @(negedge clk);

        // Simultaneous requests from reset: 0 first, 1 back-to-back.
        pulse_reset();
        exp_q.push_back(model(0, 4'b0000, 16'd3, 16'd4));
        exp_q.push_back(model(1, 4'b0001, 16'd10, 16'd3));
        fork
            req_op(0, 4'b0000, 16'd3, 16'd4, w0);
            req_op(1, 4'b0001, 16'd10, 16'd3, w1);
        join
        repeat (3) @(negedge clk);
        check("sim_wait0", w0, 1);
        check("sim_wait1", w1, 3);
        check("sim_done_spacing", done_cyc[1] - done_cyc[0], 2);

        // Fairness: both re-requesting for 8 operations.
        for (int r = 0; r < 4; r++) begin
            op_x = legal_ops[$urandom_range(0, 11)];
            op_y = legal_ops[$urandom_range(0, 11)];
            ax = W'($urandom_range(0, 65535)); bx = W'($urandom_range(0, 65535));
            ay = W'($urandom_range(0, 65535)); by = W'($urandom_range(0, 65535));
            exp_q.push_back(model(0, op_x, ax, bx));
            exp_q.push_back(model(1, op_y, ay, by));
            fork
                req_op(0, op_x, ax, bx, w0);
                req_op(1, op_y, ay, by, w1);
            join
            check("fair_wait0", (w0 <= 4), 1);
            check("fair_wait1", (w1 <= 4), 1);
        end
        repeat (3) @(negedge clk);
        check("fair_drained", exp_q.size(), 0);

        // Operand latching: a0 goes to FFFF right after ack0.
        exp_q.push_back(model(0, 4'b0000, 16'h1234, 16'h0001));
        req_op(0, 4'b0000, 16'h1234, 16'h0001, w0);
        check("latch_a0_changed", bif.a0, 16'hFFFF);
        repeat (2) @(negedge clk);

        // Reset in EXEC aborts with no done.
        @(negedge clk);
        drive(0, 1'b1, 4'b0000, 16'd7, 16'd8);
        @(negedge clk);
        check("mid_ack0", bif.ack0, 1);
        check("mid_state_exec", bif.state, EXEC);
        reset = 1'b0;
        #1;
        check("mid_rst_ack0", bif.ack0, 0);
        check("mid_rst_busy", bif.busy, 0);
        check("mid_rst_state", bif.state, IDLE);
        check("mid_rst_result", bif.result, 0);
        drive(0, 1'b0, 4'b0000, '0, '0);
        repeat (3) @(negedge clk);
        check("mid_no_done", bif.done0 | bif.done1, 0);
        reset = 1'b1;
        exp_q.push_back(model(0, 4'b0000, 16'd5, 16'd5));
        req_op(0, 4'b0000, 16'd5, 16'd5, w0);
        check("post_rst_wait", w0, 1);
        repeat (2) @(negedge clk);

`ifdef ALU_ARB_OPCHECK_EN
        // Illegal opcodes bypass the ALU.
        exp_q.push_back(model(0, 4'b1111, 16'd9, 16'd9));
        req_op(0, 4'b1111, 16'd9, 16'd9, w0);
        check("illegal_ack", w0, 1);
        exp_q.push_back(model(1, 4'b0111, 16'd1, 16'd2));
        req_op(1, 4'b0111, 16'd1, 16'd2, w1);
        repeat (2) @(negedge clk);
`endif

        repeat (4) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one alu_component between two requesters: req 0 is the execute stage, req 1 is the address/PC-increment unit.
- Round-robin arbitration with a req/ack/done handshake.
- Operands are latched on grant, the ALU is driven from registers, and the result and flags are registered for the winner.
- Sits between the decode/execute control and the single ALU instance in the processor datapath.

Parameters:
WIDTH, 16, datapath width of operands and result
OP_W, 4, width of the ALU opcode (inst_id)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
req0  input  1  requester 0 wants an ALU operation; held until ack0
op0  input  OP_W  requester 0 opcode
a0  input  WIDTH  requester 0 operand in0
b0  input  WIDTH  requester 0 operand in1
req1  input  1  requester 1 request
op1  input  OP_W  requester 1 opcode
a1  input  WIDTH  requester 1 operand in0
b1  input  WIDTH  requester 1 operand in1
ack0  output  1  one-cycle pulse: requester 0 operands latched, req0 may drop
ack1  output  1  one-cycle pulse for requester 1
done0  output  1  one-cycle pulse: result/zero/pos valid for requester 0
done1  output  1  one-cycle pulse for requester 1
result  output  WIDTH  registered ALU out, valid only while done0|done1
zero  output  1  registered ALU zero flag, valid with done
pos  output  1  registered ALU pos flag, valid with done
busy  output  1  high in EXEC and RESP

Behaviour:
- Reset (reset=0, async):
  - State becomes IDLE; ack*, done*, busy, result, zero, pos are all 0.
  - Operand registers are cleared.
  - last_grant is set to 1, so requester 0 wins the first tie.
- States: IDLE, EXEC, RESP.
- IDLE:
  - If req0|req1, pick a winner, latch op/a/b into op_r/a_r/b_r and win_r, go to EXEC.
  - Otherwise stay in IDLE.
- Arbitration:
  - Single request: that requester wins.
  - Both requesting: the requester != last_grant wins; last_grant updates on every grant.
- EXEC (1 cycle):
  - ack_win is high.
  - ALU inputs are inst_id=op_r, in0=a_r, in1=b_r. The ALU's reset input is tied inactive (its own reset is active-high).
  - At the clock edge, ALU out/zero/pos are captured into result/zero/pos; go to RESP.
- RESP (1 cycle):
  - done_win is high.
  - The same arbitration rule as IDLE applies: on a pending request, latch and go to EXEC (back-to-back); otherwise go to IDLE.
- Latency: req sampled at edge N → ack in cycle N+1 → done in cycle N+2.
  - Peak throughput is one operation per 2 cycles.
- Requester rules:
  - Must hold req and operands stable until it sees ack.
  - Must deassert req by the edge ending the ack cycle.
  - A req still high in RESP is treated as a new request.
- Result hold: result/zero/pos keep their value after done until the next EXEC capture.
  - Bench checks them only while done is high.
- Arithmetic: the block performs none itself. All arithmetic is from the ALU; width WIDTH, wrap-around per the ALU.
- Reset mid-operation: the operation is aborted with no ack/done issued, and the requester must re-request.
- Outside their state, ack0/ack1/done0/done1 are 0. At most one ack and one done are high at any time.

Optional Feature:
- Macro: ALU_ARB_OPCHECK_EN.
- When defined:
  - Any op not in the package's legal opcode set is still acked.
  - The ALU is bypassed: result=0, zero=0, pos=0.
  - An extra output illegal_op (1 bit) pulses together with done.
- When undefined: the illegal_op port is absent and every opcode goes to the ALU.

Decomposition:
- Package alu_pkg:
  - Add-class opcodes: ADD=4'b0000, 4'b0100, 4'b0110, 4'b1000, 4'b1001, 4'b1010, 4'b1011.
  - Sub-class opcodes: SUB=4'b0001, 4'b0010, 4'b0011, 4'b0101, 4'b1100.
  - State encoding: IDLE=2'd0, EXEC=2'd1, RESP=2'd2.
  - Legal-opcode function.
- Sub-module: the existing alu_component is instantiated once.
- Arbitration is a small function in this block; no separate arbiter module.

Test Plan:
- Single request, add: req0, op=0000, a=1, b=1 → ack0 one cycle later, done0 the next cycle with result=2, zero=0, pos=1; ack1/done1 stay 0.
- Single request, sub: req1, op=0001, a=1, b=1 → done1 with result=0, zero=1.
- Simultaneous requests: req0 (0000, 3, 4) and req1 (0001, 10, 3) from reset → requester 0 served first (result 7), requester 1 immediately back-to-back (result 7).
  - Check done0 and done1 are exactly 2 cycles apart and never overlap.
- Fairness: both requesters re-requesting continuously for 8 operations → grants alternate 0,1,0,1…; no requester waits more than 2 operations.
- Operand latching: change a0 to 16'hFFFF in the cycle after ack0 → result still uses the latched value.
- Reset mid-operation: assert reset during EXEC → all outputs 0 immediately, no done.
  - After release, a new req0 (0000, 5, 5) yields result=10.
  - With ALU_ARB_OPCHECK_EN defined, an illegal op (e.g. 4'b1111) gives illegal_op=1 and result=0.
